tia_audio_ctrl: RTL and testbench
=================================

TIA_AUDIO_CTRL -- requirements
Module: tia_audio_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, bus address width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port audio_tick  input  1  one-cycle audio-rate enable, two per scan line.
REQ-005 SHALL have port wr_en  input  1  one-cycle register write strobe.
REQ-006 SHALL have port wr_addr  input  ADDR_W  register address.
REQ-007 SHALL have port wr_data  input  8  write data; only the low bits needed by each register are used.
REQ-008 SHALL have port poly_bit[1:0]  input  2  bit 0 of each channel's noise/tone shift register.
REQ-009 SHALL have port audc0, audc1  output  4 each  control values driving the noise/tone generators.
REQ-010 SHALL have port shift_en[1:0]  output  2  one-cycle pulse per channel that advances that generator.
REQ-011 SHALL have port sample0, sample1  output  4 each  per-channel volume-gated sample.
REQ-012 SHALL have port mix  output  5  sum of sample0 and sample1.

Function
REQ-013 SHALL decode writes as follows: 0x15 to AUDC0[3:0], 0x16 to AUDC1[3:0], 0x17 to AUDF0[4:0], 0x18 to AUDF1[4:0], 0x19 to AUDV0[3:0], 0x1A to AUDV1[3:0]; other addresses are ignored.
REQ-014 SHALL make a written register visible on its output the cycle after wr_en.
REQ-015 SHALL keep a 5-bit divider counter per channel that changes only on audio_tick.
REQ-016 SHALL, on audio_tick, clear the counter to 0 if it equals AUDFn and assert shift_en[n] the next cycle for exactly one cycle; otherwise it SHALL increment the counter.
REQ-017 SHALL give a period of AUDFn+1 ticks; AUDF=0 SHALL pulse on every tick.
REQ-018 SHALL let the counter wrap from 31 to 0 without a pulse when a write makes AUDFn less than the current count; matching then resumes after the wrap.
REQ-019 SHALL, when wr_en and audio_tick coincide on the same channel's AUDF, compare against the old AUDF value.
REQ-020 SHALL update samplen in the cycle shift_en[n] is high: AUDVn if poly_bit[n]=1, else 0.
REQ-021 SHALL hold samplen at AUDVn continuously when AUDCn is 0x0 or 0xB (constant-level modes).
REQ-022 SHALL apply an AUDV write to a nonzero sample at the next sample update; in constant-level modes it SHALL apply on the next cycle.
REQ-023 SHALL register mix one cycle after the samples, as a zero-extended 5-bit sum with no overflow (maximum 30).
REQ-024 SHALL make both channels fully independent; simultaneous pulses on both channels are legal.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, clear all AUD registers, counters, shift_en, samples and mix to 0.
REQ-026 SHALL give reset priority over wr_en and audio_tick.
REQ-027 SHALL make an in-flight shift_en pulse asserted during reset never appear.

Configuration
REQ-028 SHALL, when macro TIA_AUDIO_MIX_EN is defined, implement the mix adder and register.
REQ-029 SHALL, without TIA_AUDIO_MIX_EN, keep the mix port present, drive it constant 0, and include no adder logic.

Structure
REQ-030 SHALL place register address constants, AUDC/AUDF/AUDV widths and constant-level mode codes in shared package tia_audio_pkg.
REQ-031 SHALL implement the divider and sample gate as sub-module tia_audio_divider, instanced once per channel.

Verification
REQ-032 SHALL test: write 0x19=0x0F, 0x15=0x0, then release reset -> sample0=15 from the cycle after the write; mix=15 with the macro, 0 without.
REQ-033 SHALL test: AUDF0=3, continuous audio_tick -> shift_en[0] pulses every 4th tick, one cycle wide.
REQ-034 SHALL test: counter at 10, write AUDF1=5 -> no pulse until the counter wraps 31 to 0 and reaches 5.
REQ-035 SHALL test: wr_en to 0x17 (value 2) coincident with a tick at count 7 with old AUDF 7 -> pulse occurs and the counter clears; the next period is 3 ticks.
REQ-036 SHALL test: AUDV0=9, AUDC0=0x8, poly_bit[0]=1 then 0 across pulses -> sample0 is 9 then 0; with AUDV1=15 and sample1=15 -> mix=24 or 30 as applicable.
REQ-037 SHALL test: rst_n low for one cycle mid-period -> all outputs 0 next cycle and the counter restarts from 0.

Source files
------------

// File: rtl/tia_audio_pkg.sv
// -----------------------------------------------------------------------------
// tia_audio_pkg
// Shared definitions for the TIA-style audio controller: register address map,
// register field widths, constant-level mode codes and the per-channel register
// bundle type.
// No ports (package).
// -----------------------------------------------------------------------------
package tia_audio_pkg;

  localparam int AUDC_W   = 4;
  localparam int AUDF_W   = 5;
  localparam int AUDV_W   = 4;
  localparam int SAMPLE_W = 4;
  localparam int MIX_W    = 5;

  // Register address map (8-bit values, resized to the bus width at use).
  localparam logic [7:0] ADDR_AUDC0 = 8'h15;
  localparam logic [7:0] ADDR_AUDC1 = 8'h16;
  localparam logic [7:0] ADDR_AUDF0 = 8'h17;
  localparam logic [7:0] ADDR_AUDF1 = 8'h18;
  localparam logic [7:0] ADDR_AUDV0 = 8'h19;
  localparam logic [7:0] ADDR_AUDV1 = 8'h1A;

  // AUDC codes in which the output sits at the volume level permanently.
  localparam logic [AUDC_W-1:0] AUDC_CONST_LO = 4'h0;
  localparam logic [AUDC_W-1:0] AUDC_CONST_HI = 4'hB;

  // Per-channel programmable registers.
  typedef struct packed {
    logic [AUDC_W-1:0] audc;
    logic [AUDF_W-1:0] audf;
    logic [AUDV_W-1:0] audv;
  } chan_regs_t;

  function automatic logic is_const_mode(input logic [AUDC_W-1:0] audc);
    return (audc == AUDC_CONST_LO) || (audc == AUDC_CONST_HI);
  endfunction

endpackage

// File: rtl/tia_audio_ctrl_divider.sv
// -----------------------------------------------------------------------------
// tia_audio_divider
// One audio channel: 5-bit frequency divider clocked by audio_tick plus the
// volume-gated sample register.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   audio_tick     : audio-rate enable
//   audf           : current (registered) divider reload value
//   audc_nxt       : AUDC value the register will hold after this edge
//   audv_nxt       : AUDV value the register will hold after this edge
//   poly_bit       : bit 0 of this channel's noise/tone shift register
//   shift_en       : one-cycle pulse advancing the noise/tone generator
//   sample         : volume-gated sample
// The *_nxt inputs let a constant-level sample follow a register write in the
// same cycle the register itself becomes visible.
// -----------------------------------------------------------------------------
module tia_audio_divider
  import tia_audio_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                audio_tick,
  input  logic [AUDF_W-1:0]   audf,
  input  logic [AUDC_W-1:0]   audc_nxt,
  input  logic [AUDV_W-1:0]   audv_nxt,
  input  logic                poly_bit,
  output logic                shift_en,
  output logic [SAMPLE_W-1:0] sample
);

  logic [AUDF_W-1:0]   cnt_r;
  logic [AUDF_W-1:0]   cnt_nxt_s;
  logic                match_s;
  logic                pulse_r;
  logic                pulse_nxt_s;
  logic [SAMPLE_W-1:0] sample_r;
  logic [SAMPLE_W-1:0] sample_nxt_s;

  // Compare against the AUDF value held before this edge; a count above a
  // newly lowered AUDF simply runs on and wraps 31 -> 0 without a pulse.
  assign match_s = (cnt_r == audf);

  // Divider next state and pulse request.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    pulse_nxt_s = 1'b0;
    if (audio_tick) begin
      if (match_s) begin
        cnt_nxt_s   = {AUDF_W{1'b0}};
        pulse_nxt_s = 1'b1;
      end else begin
        cnt_nxt_s   = cnt_r + 5'd1;
        pulse_nxt_s = 1'b0;
      end
    end else begin
      cnt_nxt_s   = cnt_r;
      pulse_nxt_s = 1'b0;
    end
  end

  // Sample next state: constant-level modes track AUDV every cycle, otherwise
  // the sample is re-gated only while the shift pulse is high.
  always_comb begin
    sample_nxt_s = sample_r;
    if (is_const_mode(audc_nxt)) begin
      sample_nxt_s = audv_nxt;
    end else if (pulse_r) begin
      sample_nxt_s = poly_bit ? audv_nxt : 4'd0;
    end else begin
      sample_nxt_s = sample_r;
    end
  end

  // Divider, pulse and sample registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r    <= {AUDF_W{1'b0}};
      pulse_r  <= 1'b0;
      sample_r <= {SAMPLE_W{1'b0}};
    end else begin
      cnt_r    <= cnt_nxt_s;
      pulse_r  <= pulse_nxt_s;
      sample_r <= sample_nxt_s;
    end
  end

  assign shift_en = pulse_r;
  assign sample   = sample_r;

endmodule

// File: rtl/tia_audio_ctrl.sv
// -----------------------------------------------------------------------------
// tia_audio_ctrl
// Two-channel TIA-style audio control block: AUDC/AUDF/AUDV register file,
// per-channel frequency divider and volume gate, optional sample mixer.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   audio_tick        : audio-rate enable (two per scan line)
//   wr_en/addr/data   : register write port
//   poly_bit[1:0]     : bit 0 of each channel's noise/tone shift register
//   audc0, audc1      : control values for the noise/tone generators
//   shift_en[1:0]     : per-channel generator advance pulse
//   sample0, sample1  : per-channel volume-gated sample
//   mix               : registered sum of the samples
// Build option: define TIA_AUDIO_MIX_EN to include the mix adder; without it
// mix is tied to 0.
// -----------------------------------------------------------------------------
module tia_audio_ctrl
  import tia_audio_pkg::*;
#(
  parameter int ADDR_W = 6
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                audio_tick,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [7:0]          wr_data,
  input  logic [1:0]          poly_bit,
  output logic [AUDC_W-1:0]   audc0,
  output logic [AUDC_W-1:0]   audc1,
  output logic [1:0]          shift_en,
  output logic [SAMPLE_W-1:0] sample0,
  output logic [SAMPLE_W-1:0] sample1,
  output logic [MIX_W-1:0]    mix
);

  chan_regs_t regs_r     [2];
  chan_regs_t regs_nxt_s [2];

  // Upper data bits are not used by any register.
  logic unused_wr_data_s;
  assign unused_wr_data_s = ^wr_data[7:5];

  // Register write decode; unknown addresses leave everything unchanged.
  always_comb begin
    regs_nxt_s = regs_r;
    if (wr_en) begin
      case (wr_addr)
        ADDR_W'(ADDR_AUDC0): regs_nxt_s[0].audc = wr_data[AUDC_W-1:0];
        ADDR_W'(ADDR_AUDC1): regs_nxt_s[1].audc = wr_data[AUDC_W-1:0];
        ADDR_W'(ADDR_AUDF0): regs_nxt_s[0].audf = wr_data[AUDF_W-1:0];
        ADDR_W'(ADDR_AUDF1): regs_nxt_s[1].audf = wr_data[AUDF_W-1:0];
        ADDR_W'(ADDR_AUDV0): regs_nxt_s[0].audv = wr_data[AUDV_W-1:0];
        ADDR_W'(ADDR_AUDV1): regs_nxt_s[1].audv = wr_data[AUDV_W-1:0];
        default:             regs_nxt_s = regs_r;
      endcase
    end else begin
      regs_nxt_s = regs_r;
    end
  end

  // Register file.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        regs_r[i] <= regs_nxt_s[i];
      end
    end
  end

  assign audc0 = regs_r[0].audc;
  assign audc1 = regs_r[1].audc;

  tia_audio_divider u_div0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .audio_tick (audio_tick),
    .audf       (regs_r[0].audf),
    .audc_nxt   (regs_nxt_s[0].audc),
    .audv_nxt   (regs_nxt_s[0].audv),
    .poly_bit   (poly_bit[0]),
    .shift_en   (shift_en[0]),
    .sample     (sample0)
  );

  tia_audio_divider u_div1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .audio_tick (audio_tick),
    .audf       (regs_r[1].audf),
    .audc_nxt   (regs_nxt_s[1].audc),
    .audv_nxt   (regs_nxt_s[1].audv),
    .poly_bit   (poly_bit[1]),
    .shift_en   (shift_en[1]),
    .sample     (sample1)
  );

`ifdef TIA_AUDIO_MIX_EN
  logic [MIX_W-1:0] mix_r;

  // Mixer register: zero-extended sum, cannot overflow (15 + 15 = 30).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mix_r <= {MIX_W{1'b0}};
    end else begin
      mix_r <= {1'b0, sample0} + {1'b0, sample1};
    end
  end

  assign mix = mix_r;
`else
  assign mix = 5'd0;
`endif

endmodule

// File: tb/tb_tia_audio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tia_audio_ctrl
// Self-checking bench for tia_audio_ctrl. A cycle model pushes the expected
// outputs for every clock edge into a queue; after each edge the entry is
// popped and compared with the DUT. Directed checks cover the key scenarios.
// -----------------------------------------------------------------------------
module tb_tia_audio_ctrl;

`ifdef TIA_AUDIO_MIX_EN
  localparam bit MIX_ON = 1'b1;
`else
  localparam bit MIX_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       audio_tick;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic [1:0] poly_bit;
  logic [3:0] audc0, audc1;
  logic [1:0] shift_en;
  logic [3:0] sample0, sample1;
  logic [4:0] mix;

  always #5 clk = ~clk;

  tia_audio_ctrl #(.ADDR_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .audio_tick (audio_tick),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .poly_bit   (poly_bit),
    .audc0      (audc0),
    .audc1      (audc1),
    .shift_en   (shift_en),
    .sample0    (sample0),
    .sample1    (sample1),
    .mix        (mix)
  );

  typedef struct packed {
    logic [3:0] audc0;
    logic [3:0] audc1;
    logic [1:0] shift_en;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [4:0] mix;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // reference model state
  logic [3:0] m_audc [2];
  logic [4:0] m_audf [2];
  logic [3:0] m_audv [2];
  logic [4:0] m_cnt  [2];
  logic       m_sh   [2];
  logic [3:0] m_samp [2];
  logic [4:0] m_mix;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    logic [3:0] nc [2];
    logic [4:0] nf [2];
    logic [3:0] nv [2];
    obs_t e;
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        m_audc[n] = 4'd0; m_audf[n] = 5'd0; m_audv[n] = 4'd0;
        m_cnt[n] = 5'd0; m_sh[n] = 1'b0; m_samp[n] = 4'd0;
      end
      m_mix = 5'd0;
    end else begin
      nc = m_audc; nf = m_audf; nv = m_audv;
      if (wr_en) begin
        case (wr_addr)
          6'h15: nc[0] = wr_data[3:0];
          6'h16: nc[1] = wr_data[3:0];
          6'h17: nf[0] = wr_data[4:0];
          6'h18: nf[1] = wr_data[4:0];
          6'h19: nv[0] = wr_data[3:0];
          6'h1A: nv[1] = wr_data[3:0];
          default: ;
        endcase
      end
      m_mix = MIX_ON ? (5'(m_samp[0]) + 5'(m_samp[1])) : 5'd0;
      for (int n = 0; n < 2; n++) begin
        if (nc[n] == 4'h0 || nc[n] == 4'hB) m_samp[n] = nv[n];
        else if (m_sh[n]) m_samp[n] = poly_bit[n] ? nv[n] : 4'd0;
        m_sh[n] = audio_tick && (m_cnt[n] == m_audf[n]);
        if (audio_tick) m_cnt[n] = (m_cnt[n] == m_audf[n]) ? 5'd0 : m_cnt[n] + 5'd1;
      end
      m_audc = nc; m_audf = nf; m_audv = nv;
    end
    e.audc0 = m_audc[0]; e.audc1 = m_audc[1];
    e.shift_en = {m_sh[1], m_sh[0]};
    e.s0 = m_samp[0]; e.s1 = m_samp[1]; e.mix = m_mix;
    exp_q.push_back(e);
  endtask

  // One clock: push expectation, wait for the edge, pop and compare.
  task automatic cyc();
    obs_t e;
    model_edge();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("sb_audc0",    32'(audc0),    32'(e.audc0));
    chk("sb_audc1",    32'(audc1),    32'(e.audc1));
    chk("sb_shift_en", 32'(shift_en), 32'(e.shift_en));
    chk("sb_sample0",  32'(sample0),  32'(e.s0));
    chk("sb_sample1",  32'(sample1),  32'(e.s1));
    chk("sb_mix",      32'(mix),      32'(e.mix));
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic reset_cycle();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic ticks(input int n, output int p0, output int p1, output int adj0);
    logic prev0;
    p0 = 0; p1 = 0; adj0 = 0; prev0 = 1'b0;
    for (int i = 0; i < n; i++) begin
      audio_tick = 1'b1;
      cyc();
      if (shift_en[0]) p0++;
      if (shift_en[1]) p1++;
      if (shift_en[0] && prev0) adj0++;
      prev0 = shift_en[0];
    end
    audio_tick = 1'b0;
  endtask

  // Number of ticks until the channel pulses; -1 if none within the limit.
  task automatic ticks_to_pulse(input int ch, input int limit, output int idx);
    idx = -1;
    for (int i = 1; i <= limit; i++) begin
      audio_tick = 1'b1;
      cyc();
      if (shift_en[ch]) begin
        idx = i;
        break;
      end
    end
    audio_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, p1, adj, idx;
    rst_n = 1'b0; audio_tick = 1'b0; wr_en = 1'b0;
    wr_addr = 6'd0; wr_data = 8'd0; poly_bit = 2'b00;
    for (int n = 0; n < 2; n++) begin
      m_audc[n] = 4'd0; m_audf[n] = 5'd0; m_audv[n] = 4'd0;
      m_cnt[n] = 5'd0; m_sh[n] = 1'b0; m_samp[n] = 4'd0;
    end
    m_mix = 5'd0;

    // Reset, with a write attempted during reset (must be ignored).
    cyc();
    wr_en = 1'b1; wr_addr = 6'h19; wr_data = 8'h0F; audio_tick = 1'b1;
    cyc();
    chk("rst_sample0", 32'(sample0), 32'd0);
    chk("rst_shift", 32'(shift_en), 32'd0);
    wr_en = 1'b0; audio_tick = 1'b0; rst_n = 1'b1;

    // Constant-level mode: sample follows AUDV the cycle after the write.
    wr(6'h19, 8'h0F);
    chk("const_sample0", 32'(sample0), 32'd15);
    wr(6'h15, 8'h00);
    chk("const_sample0_hold", 32'(sample0), 32'd15);
    chk("const_mix", 32'(mix), MIX_ON ? 32'd15 : 32'd0);
    wr(6'h3F, 8'hFF);  // unmapped address
    chk("unmapped_audc0", 32'(audc0), 32'd0);

    // AUDF0=3 -> every 4th tick; AUDF1=0 -> every tick.
    wr(6'h17, 8'h03);
    wr(6'h18, 8'h00);
    ticks(12, p0, p1, adj);
    chk("div4_pulses", 32'(p0), 32'd3);
    chk("div4_width", 32'(adj), 32'd0);
    chk("div1_pulses", 32'(p1), 32'd12);

    // Lowering AUDF1 below the count: wrap 31->0 then reach 5.
    reset_cycle();
    wr(6'h18, 8'd20);
    ticks(10, p0, p1, adj);
    chk("pre_lower_pulses1", 32'(p1), 32'd0);
    wr(6'h18, 8'd5);
    ticks_to_pulse(1, 40, idx);
    chk("wrap_ticks_to_pulse", 32'(idx), 32'd28);

    // Coincident AUDF0 write and tick: old value 7 matches count 7.
    reset_cycle();
    wr(6'h17, 8'd7);
    ticks(7, p0, p1, adj);
    chk("pre_coinc_pulses0", 32'(p0), 32'd0);
    wr_en = 1'b1; wr_addr = 6'h17; wr_data = 8'd2; audio_tick = 1'b1;
    cyc();
    wr_en = 1'b0; audio_tick = 1'b0;
    chk("coinc_pulse", 32'(shift_en[0]), 32'd1);
    ticks_to_pulse(0, 10, idx);
    chk("coinc_next_period", 32'(idx), 32'd3);

    // Volume gating and mix.
    reset_cycle();
    wr(6'h19, 8'd9);
    wr(6'h15, 8'h08);
    wr(6'h1A, 8'd15);
    chk("ch1_const_sample", 32'(sample1), 32'd15);
    poly_bit = 2'b01; audio_tick = 1'b1;
    cyc();
    audio_tick = 1'b0;
    chk("gate_pulse0", 32'(shift_en[0]), 32'd1);
    cyc();
    chk("gate_sample0_on", 32'(sample0), 32'd9);
    cyc();
    chk("gate_mix24", 32'(mix), MIX_ON ? 32'd24 : 32'd0);
    wr(6'h19, 8'd15);
    chk("audv_deferred", 32'(sample0), 32'd9);
    audio_tick = 1'b1;
    cyc();
    audio_tick = 1'b0;
    cyc();
    chk("gate_sample0_15", 32'(sample0), 32'd15);
    cyc();
    chk("gate_mix30", 32'(mix), MIX_ON ? 32'd30 : 32'd0);
    poly_bit = 2'b00; audio_tick = 1'b1;
    cyc();
    audio_tick = 1'b0;
    cyc();
    chk("gate_sample0_off", 32'(sample0), 32'd0);
    cyc();
    chk("gate_mix15", 32'(mix), MIX_ON ? 32'd15 : 32'd0);

    // Mid-period reset with a matching tick in flight.
    reset_cycle();
    wr(6'h19, 8'd7);
    wr(6'h17, 8'd3);
    ticks(3, p0, p1, adj);
    rst_n = 1'b0; audio_tick = 1'b1; wr_en = 1'b1; wr_addr = 6'h16; wr_data = 8'h05;
    cyc();
    chk("midrst_shift", 32'(shift_en), 32'd0);
    chk("midrst_sample0", 32'(sample0), 32'd0);
    chk("midrst_audc1", 32'(audc1), 32'd0);
    chk("midrst_mix", 32'(mix), 32'd0);
    rst_n = 1'b1; audio_tick = 1'b0; wr_en = 1'b0;
    cyc();
    chk("midrst_no_late_pulse", 32'(shift_en), 32'd0);
    wr(6'h17, 8'd7);
    ticks_to_pulse(0, 12, idx);
    chk("midrst_restart", 32'(idx), 32'd8);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
